register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/reg_file_pkg.sv | 8 +
 rtl/rf_entry.sv | 17 +
 rtl/register_file.sv | 34 +++
 tb/tb_register_file.sv | 92 +++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared register file widths, depth and word/address types
package reg_file_pkg;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam int DEPTH_DEF = 2 ** ADDR_WIDTH_DEF;
  typedef logic [DATA_WIDTH_DEF-1:0] word_t;
  typedef logic [ADDR_WIDTH_DEF-1:0] addr_t;
endpackage

// File: rtl/rf_entry.sv
// rf_entry: one storage word with synchronous reset and write enable
module rf_entry #(
  parameter int W = reg_file_pkg::DATA_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] q_q;
  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else if (we_i) q_q <= d_i;
  end
  assign q_o = q_q;
endmodule

// File: rtl/register_file.sv
// register_file: 1W/1R register file, combinational read; REG_FILE_BYPASS_EN forwards same-cycle writes to rd_o
module register_file
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] wa_i,
  input  logic [DATA_WIDTH-1:0] wd_i,
  input  logic [ADDR_WIDTH-1:0] ra_i,
  output logic [DATA_WIDTH-1:0] rd_o
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  logic [DEPTH-1:0] we_vec;
  logic [DATA_WIDTH-1:0] q [DEPTH];
  always_comb we_vec = we_i ? {{(DEPTH-1){1'b0}}, 1'b1} << wa_i : '0;
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    rf_entry #(.W(DATA_WIDTH)) u_entry (
      .clk (clk),
      .rst (rst),
      .we_i(we_vec[i]),
      .d_i (wd_i),
      .q_o (q[i])
    );
  end
`ifdef REG_FILE_BYPASS_EN
  assign rd_o = (we_i && !rst && wa_i == ra_i) ? wd_i : q[ra_i];
`else
  assign rd_o = q[ra_i];
`endif
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed + random scoreboard bench for register_file
module tb_register_file;
  logic clk = 0, rst = 0, we_i = 0;
  logic [4:0] wa_i = '0, ra_i = '0;
  logic [31:0] wd_i = '0, rd_o;
  logic [31:0] m [32];
  logic [31:0] sb [$];
  int total = 0, bad = 0;

  register_file dut (
    .clk (clk),
    .rst (rst),
    .we_i(we_i),
    .wa_i(wa_i),
    .wd_i(wd_i),
    .ra_i(ra_i),
    .rd_o(rd_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] expect_rd();
`ifdef REG_FILE_BYPASS_EN
    if (we_i && !rst && wa_i == ra_i) return wd_i;
`endif
    return m[ra_i];
  endfunction

  task automatic check(input string tag);
    logic [31:0] e;
    e = sb.pop_front();
    total++;
    assert (rd_o === e) else begin
      bad++;
      $error("FAIL %s ra=%0d rd_o=%h expected=%h", tag, ra_i, rd_o, e);
    end
  endtask

  task automatic cyc(input logic r, input logic we, input logic [4:0] wa,
                     input logic [31:0] wd, input logic [4:0] ra, input string tag);
    @(negedge clk);
    rst = r; we_i = we; wa_i = wa; wd_i = wd; ra_i = ra;
    #1;
    sb.push_back(expect_rd());
    check({tag, "_pre"});
    @(posedge clk);
    if (r) foreach (m[k]) m[k] = '0;
    else if (we) m[wa] = wd;
    #1;
    sb.push_back(expect_rd());
    check({tag, "_post"});
  endtask

  task automatic rd(input logic [4:0] ra, input string tag);
    @(negedge clk);
    rst = 0; we_i = 0; ra_i = ra;
    #1;
    sb.push_back(m[ra]);
    check(tag);
  endtask

  initial begin
    foreach (m[k]) m[k] = '0;
    @(negedge clk);
    rst = 1; we_i = 1; wa_i = 5'd2; wd_i = 32'h1234;
    @(posedge clk);
    #1;
    for (int a = 0; a < 32; a++) rd(5'(a), "reset_zero");
    for (int a = 1; a <= 4; a++) cyc(0, 1, 5'(a), 32'(a), 5'(a), "wr_seq");
    for (int a = 1; a <= 4; a++) rd(5'(a), "rd_seq");
    cyc(0, 0, 5'd5, 32'hDEADBEEF, 5'd5, "we_low");
    rd(5'd5, "we_low_rd");
    cyc(0, 1, 5'd31, 32'hFFFFFFFF, 5'd31, "wr31");
    cyc(0, 1, 5'd0, 32'h1, 5'd0, "wr0");
    cyc(1, 0, 5'd0, 32'h0, 5'd31, "mid_rst");
    rd(5'd31, "rst_clr31");
    rd(5'd0, "rst_clr0");
    rd(5'd1, "rst_clr1");
    cyc(0, 1, 5'd9, 32'h77, 5'd9, "wr_after_rst");
    cyc(0, 1, 5'd7, 32'hA, 5'd1, "wr7a");
    cyc(0, 1, 5'd7, 32'hB, 5'd7, "same_addr");
    cyc(1, 1, 5'd3, 32'h55, 5'd3, "rst_prio");
    rd(5'd3, "rst_prio_rd");
    rd(5'd9, "rst_clr9");
    for (int i = 0; i < 60; i++)
      cyc(0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
          5'($urandom_range(0, 31)), "rand");
    for (int a = 0; a < 32; a++) rd(5'(a), "final_scan");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
